// File: rtl/def_data_tx_if.sv
//-----------------------------------------------------------------------------
// def_data_tx_if
//  Bundle of the word-side handshake and status signals of def_data_tx.
//
//  Handshake: a word on din is taken at a rising clk edge where validin and
//  readyin are both 1. readyin is registered and reflects the one-word holding
//  buffer being empty. validin while readyin=0 is ignored, and din does not
//  need to be held once the accepting edge has passed.
//
//  Signals
//   din        DATA_W  word to send                  (master -> slave)
//   validin    1       din valid                     (master -> slave)
//   readyin    1       holding buffer empty          (slave  -> master)
//   d_tr       1       serial line, idle high        (slave  -> master)
//   busy       1       FSM active or buffer full     (slave  -> master)
//   frame_cnt  16      frames sent, wraps            (slave  -> master)
//
//  Modports: master = word source / line observer, slave = transmitter.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
interface def_data_tx_if #(
   parameter int DATA_W = 36
);
   logic [DATA_W-1:0] din;
   logic              validin;
   logic              readyin;
   logic              d_tr;
   logic              busy;
   logic [15:0]       frame_cnt;

   modport master (
      output din,
      output validin,
      input  readyin,
      input  d_tr,
      input  busy,
      input  frame_cnt
   );

   modport slave (
      input  din,
      input  validin,
      output readyin,
      output d_tr,
      output busy,
      output frame_cnt
   );
endinterface

// File: rtl/def_data_tx.sv
//-----------------------------------------------------------------------------
// def_data_tx
//  Defectoscope-side serial data transmitter (far end of receiver_dd).
//  Serializes DATA_W-bit measurement words onto a single line, one bit per
//  rising edge of the link clock. A one-word holding buffer lets the source
//  hand over the next word while the shifter is still busy with the current
//  one, so continuous traffic runs with no idle time beyond the gap.
//
//  Line frame: start(0), DATA_W data bits MSB first, [even parity], stop(1),
//  then GAP_BITS idle-high bits. With back-to-back words the start bits are
//  DATA_W+2+GAP_BITS cycles apart (+1 with parity).
//
//  Build option
//   DEF_TX_PARITY_EN  when defined, an even-parity bit follows the data and
//                     the FSM has a PARITY state; when undefined the data goes
//                     straight to the stop bit.
//
//  Parameters
//   DATA_W    payload width (bit DATA_W-1 is sent first)
//   GAP_BITS  idle-high bits after the stop bit, legal range 1..15
//
//  Ports
//   clk          in   link bit clock (clkx)
//   reset        in   asynchronous, active-high reset
//   bus          slave modport of def_data_tx_if (din/validin/readyin,
//                d_tr, busy, frame_cnt)
//   dbg_state_o  out  current FSM state encoding, for checkers
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module def_data_tx #(
   parameter int DATA_W   = 36,
   parameter int GAP_BITS = 2
) (
   input  logic                clk,
   input  logic                reset,
   def_data_tx_if.slave        bus,
   output logic [2:0]          dbg_state_o
);

   // Bit counter only has to reach DATA_W-1; gap counter reaches GAP_BITS (<=15).
   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int GAP_W = 4;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_BITS);

`ifdef DEF_TX_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DATA   = 3'd1,
      S_PARITY = 3'd2,
      S_STOP   = 3'd3,
      S_GAP    = 3'd4
   } state_e;
`else
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DATA   = 3'd1,
      S_STOP   = 3'd3,
      S_GAP    = 3'd4
   } state_e;
`endif

   state_e              state_q;
   logic [DATA_W-1:0]   buf_q;
   logic                buf_full_q;
   logic                readyin_q;
   logic [DATA_W-1:0]   shreg_q;
   logic [CNT_W-1:0]    bit_cnt_q;
   logic [GAP_W-1:0]    gap_cnt_q;
   logic                d_tr_q;
   logic [15:0]         frame_cnt_q;
`ifdef DEF_TX_PARITY_EN
   logic                parity_q;
`endif

   logic                accept;
   logic                gap_last;
   logic                load;
   logic                buf_full_d;

   // readyin_q is kept equal to ~buf_full_q out of reset, so an accept can
   // never coincide with a load: a load needs the buffer full (readyin=0).
   assign accept   = bus.validin & readyin_q;
   assign gap_last = (state_q == S_GAP) && (gap_cnt_q == GAP_LAST);

   // The shifter is loaded either from IDLE or straight from the last gap
   // cycle, which is what keeps back-to-back frames at the minimum spacing.
   assign load = buf_full_q && ((state_q == S_IDLE) || gap_last);

   always_comb begin
      buf_full_d = buf_full_q;
      if (load) begin
         buf_full_d = 1'b0;
      end else if (accept) begin
         buf_full_d = 1'b1;
      end
   end

   //--------------------------------------------------------------------------
   // Buffer, shifter and frame FSM. All outputs are registered here so the
   // serial line carries no combinational glitches.
   //--------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         buf_q       <= '0;
         buf_full_q  <= 1'b0;
         readyin_q   <= 1'b0;
         shreg_q     <= '0;
         bit_cnt_q   <= '0;
         gap_cnt_q   <= '0;
         d_tr_q      <= 1'b1;
         frame_cnt_q <= '0;
`ifdef DEF_TX_PARITY_EN
         parity_q    <= 1'b0;
`endif
      end else begin
         buf_full_q <= buf_full_d;
         readyin_q  <= ~buf_full_d;

         if (accept) begin
            buf_q <= bus.din;
         end

         if (load) begin
            // Start bit goes out on this edge; data MSB follows on the next.
            shreg_q   <= buf_q;
            bit_cnt_q <= '0;
            d_tr_q    <= 1'b0;
            state_q   <= S_DATA;
`ifdef DEF_TX_PARITY_EN
            parity_q  <= ^buf_q;
`endif
         end else begin
            case (state_q)
               S_IDLE: begin
                  d_tr_q <= 1'b1;
               end

               S_DATA: begin
                  d_tr_q  <= shreg_q[DATA_W-1];
                  shreg_q <= shreg_q << 1;
                  if (bit_cnt_q == CNT_LAST) begin
`ifdef DEF_TX_PARITY_EN
                     state_q <= S_PARITY;
`else
                     state_q <= S_STOP;
`endif
                  end else begin
                     bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                  end
               end

`ifdef DEF_TX_PARITY_EN
               S_PARITY: begin
                  // XOR of the data makes the total count of ones even.
                  d_tr_q  <= parity_q;
                  state_q <= S_STOP;
               end
`endif

               S_STOP: begin
                  // A frame counts only once its stop bit is on the line.
                  d_tr_q      <= 1'b1;
                  frame_cnt_q <= frame_cnt_q + 16'd1;
                  gap_cnt_q   <= '0;
                  state_q     <= S_GAP;
               end

               S_GAP: begin
                  // GAP_BITS idle bits follow the stop bit; the edge after them
                  // either starts the next frame (load, above) or idles.
                  d_tr_q <= 1'b1;
                  if (gap_last) begin
                     state_q <= S_IDLE;
                  end else begin
                     gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                  end
               end

               default: begin
                  d_tr_q  <= 1'b1;
                  state_q <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign bus.readyin   = readyin_q;
   assign bus.d_tr      = d_tr_q;
   assign bus.busy      = (state_q != S_IDLE) | buf_full_q;
   assign bus.frame_cnt = frame_cnt_q;
   assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_def_data_tx.sv
`timescale 1ns/1ps
module tb_def_data_tx;

   localparam int DATA_W   = 36;
   localparam int GAP_BITS = 2;
`ifdef DEF_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   // Line bits from start to stop inclusive, and start-to-start with traffic.
   localparam int FRAME_LEN = DATA_W + 2 + PAR;
   localparam int PERIOD    = FRAME_LEN + GAP_BITS;

   //--------------------------------------------------------------------------
   // Clock / reset
   //--------------------------------------------------------------------------
   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] dbg_state;

   always #5 clk = ~clk;

   def_data_tx_if #(.DATA_W(DATA_W)) bus();

   def_data_tx #(
      .DATA_W   (DATA_W),
      .GAP_BITS (GAP_BITS)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   //--------------------------------------------------------------------------
   // Scoreboard state
   //--------------------------------------------------------------------------
   int                n_tests = 0;
   int                n_fail  = 0;
   logic [15:0]       exp_cnt;
   logic [DATA_W-1:0] exp_q[$];
   logic              line_q[$];

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One link clock; outputs are sampled 1 ns after the edge and recorded.
   task automatic tick();
      @(posedge clk);
      #1;
      line_q.push_back(bus.d_tr);
   endtask

   function automatic logic [DATA_W-1:0] rand_word();
      logic [63:0] r;
      r = {$urandom, $urandom};
      return r[DATA_W-1:0];
   endfunction

   task automatic wait_ready(input string tag);
      int n = 0;
      while (bus.readyin !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      check({tag, "_ready"}, 128'(bus.readyin), 128'(1));
   endtask

   // Expected line for one isolated frame, first transmitted bit highest.
   function automatic logic [127:0] line_model(input logic [DATA_W-1:0] w);
      logic [127:0] l;
      l = '0;
      l = {l[126:0], 1'b0};
      for (int i = 0; i < DATA_W; i++) l = {l[126:0], w[DATA_W-1-i]};
`ifdef DEF_TX_PARITY_EN
      l = {l[126:0], ^w};
`endif
      l = {l[126:0], 1'b1};
      for (int i = 0; i < GAP_BITS; i++) l = {l[126:0], 1'b1};
      return l;
   endfunction

   // Single word from an idle transmitter: exact line pattern, latency,
   // frame counter at the stop bit, and return to idle afterwards.
   task automatic send_frame_checked(input logic [DATA_W-1:0] w, input string tag);
      logic [127:0] obs_line;
      logic [15:0]  cnt_at_stop;
      int           n;
      n = FRAME_LEN + GAP_BITS;
      obs_line = '0;
      cnt_at_stop = '0;
      wait_ready(tag);
      bus.din     = w;
      bus.validin = 1'b1;
      tick();
      bus.validin = 1'b0;
      bus.din     = rand_word();
      check({tag, "_busy_full"}, 128'(bus.busy), 128'(1));
      check({tag, "_ready_low"}, 128'(bus.readyin), 128'(0));
      for (int i = 0; i < n; i++) begin
         tick();
         obs_line = {obs_line[126:0], bus.d_tr};
         if (i == FRAME_LEN - 1) cnt_at_stop = bus.frame_cnt;
      end
      check({tag, "_line"}, obs_line, line_model(w));
      exp_cnt = exp_cnt + 16'd1;
      check({tag, "_cnt"}, 128'(cnt_at_stop), 128'(exp_cnt));
      tick();
      check({tag, "_idle_busy"}, 128'(bus.busy), 128'(0));
      check({tag, "_idle_line"}, 128'(bus.d_tr), 128'(1));
   endtask

   // validin held high; accepted words are those presented while readyin=1.
   // With churn, din changes every cycle, including while readyin=0.
   task automatic run_stream(input int n_words, input bit churn, input string tag);
      int                acc;
      int                cyc;
      int                idx;
      int                nfr;
      int                last;
      logic              rdy;
      logic [DATA_W-1:0] cur;
      logic [DATA_W-1:0] w;
      logic [DATA_W-1:0] exp_w;
      acc = 0;
      cyc = 0;
      line_q.delete();
      exp_q.delete();
      cur = rand_word();
      while (acc < n_words && cyc < 2000) begin
         bus.validin = 1'b1;
         bus.din     = cur;
         rdy = bus.readyin;
         tick();
         cyc++;
         if (rdy === 1'b1) begin
            exp_q.push_back(cur);
            acc++;
            cur = rand_word();
         end else if (churn) begin
            cur = rand_word();
         end
      end
      bus.validin = 1'b0;
      check({tag, "_accepted"}, 128'(acc), 128'(n_words));
      cyc = 0;
      while (bus.busy === 1'b1 && cyc < 2000) begin
         tick();
         cyc++;
      end
      check({tag, "_drain"}, 128'(bus.busy), 128'(0));

      // Decode the recorded line as a receiver would.
      idx  = 0;
      nfr  = 0;
      last = -1;
      while (idx < line_q.size()) begin
         if (line_q[idx] !== 1'b0) begin
            idx++;
            continue;
         end
         if (idx + FRAME_LEN > line_q.size()) break;
         w = '0;
         for (int i = 0; i < DATA_W; i++) w = {w[DATA_W-2:0], line_q[idx+1+i]};
`ifdef DEF_TX_PARITY_EN
         check({tag, "_parity"}, 128'(^w ^ line_q[idx+1+DATA_W]), 128'(0));
`endif
         check({tag, "_stop"}, 128'(line_q[idx+FRAME_LEN-1]), 128'(1));
         if (last >= 0) check({tag, "_spacing"}, 128'(idx - last), 128'(PERIOD));
         if (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            check({tag, "_word"}, 128'(w), 128'(exp_w));
         end
         nfr++;
         last = idx;
         idx += FRAME_LEN;
      end
      check({tag, "_frames"}, 128'(nfr), 128'(n_words));
      exp_cnt = exp_cnt + 16'(n_words);
      check({tag, "_cnt"}, 128'(bus.frame_cnt), 128'(exp_cnt));
   endtask

   //--------------------------------------------------------------------------
   // Watchdog
   //--------------------------------------------------------------------------
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, state=%0d", dbg_state);
      $fatal(1, "watchdog");
   end

   //--------------------------------------------------------------------------
   // Directed sequence
   //--------------------------------------------------------------------------
   initial begin
      logic [DATA_W-1:0] w;

      reset       = 1'b1;
      bus.validin = 1'b0;
      bus.din     = '0;
      exp_cnt     = '0;

      // 1: reset values and release
      repeat (2) @(posedge clk);
      #1;
      check("rst_d_tr", 128'(bus.d_tr), 128'(1));
      check("rst_ready", 128'(bus.readyin), 128'(0));
      check("rst_busy", 128'(bus.busy), 128'(0));
      check("rst_cnt", 128'(bus.frame_cnt), 128'(0));
      #2;
      reset = 1'b0;
      #1;
      check("rel_ready_pre", 128'(bus.readyin), 128'(0));
      tick();
      check("rel_ready_edge", 128'(bus.readyin), 128'(1));
      repeat (3) tick();
      check("rel_d_tr", 128'(bus.d_tr), 128'(1));
      check("rel_busy", 128'(bus.busy), 128'(0));
      check("rel_cnt", 128'(bus.frame_cnt), 128'(0));

      // 2: directed word, then boundary data patterns and random words
      send_frame_checked(36'h9_1234_5678, "t2_word");
      send_frame_checked('0, "t2_zeros");
      send_frame_checked('1, "t2_ones");
      for (int k = 0; k < 3; k++) send_frame_checked(rand_word(), "t2_rand");

      // 3: three words back-to-back, din held per word
      run_stream(3, 1'b0, "t3_b2b");

      // 6: validin held with din changing every cycle
      run_stream(int'($urandom_range(8, 5)), 1'b1, "t6_churn");

      // 4: reset asserted while data bit 10 is on the line
      w = rand_word();
      wait_ready("t4");
      bus.din     = w;
      bus.validin = 1'b1;
      tick();
      bus.validin = 1'b0;
      tick();
      check("t4_start", 128'(bus.d_tr), 128'(0));
      repeat (10) tick();
      check("t4_bit10", 128'(bus.d_tr), 128'(w[DATA_W-10]));
      check("t4_cnt_mid", 128'(bus.frame_cnt), 128'(exp_cnt));
      reset = 1'b1;
      #1;
      check("t4_async_d_tr", 128'(bus.d_tr), 128'(1));
      check("t4_async_ready", 128'(bus.readyin), 128'(0));
      check("t4_async_busy", 128'(bus.busy), 128'(0));
      check("t4_async_cnt", 128'(bus.frame_cnt), 128'(0));
      exp_cnt = '0;
      repeat (2) tick();
      check("t4_hold_d_tr", 128'(bus.d_tr), 128'(1));
      #2;
      reset = 1'b0;
      #1;
      check("t4_ready_pre", 128'(bus.readyin), 128'(0));
      tick();
      check("t4_ready_edge", 128'(bus.readyin), 128'(1));
      send_frame_checked(rand_word(), "t4_after");

      // 5: counter preloaded near the top wraps on the stop bit
      @(negedge clk);
      force dut.frame_cnt_q = 16'hFFFE;
      #1;
      release dut.frame_cnt_q;
      exp_cnt = 16'hFFFE;
      #1;
      check("t5_preload", 128'(bus.frame_cnt), 128'(16'hFFFE));
      send_frame_checked(rand_word(), "t5_ffff");
      send_frame_checked(rand_word(), "t5_wrap");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
